pr_stream_reader: RTL and testbench
===================================

PR_STREAM_READER -- requirements
Module: pr_stream_reader

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent read streams, for example vertex and in-edge.
REQ-002 Parameter DATA_W, default 512: AXI read data width; E = DATA_W/ELEM_W elements per line (8 at defaults).
REQ-003 Parameter ELEM_W, default 64: width of one output element.
REQ-004 Parameter LOG_DEPTH, default 4: per-channel line FIFO depth D = 2^LOG_DEPTH.
REQ-005 Parameter MAX_BURST, default 4: maximum beats per AR request.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse; captures the cfg_* buses.
REQ-009 cfg_base  in  NUM_CH*64  per-channel byte base address, 64-byte aligned (bits [5:0] ignored).
REQ-010 cfg_count  in  NUM_CH*64  per-channel element count.
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle pulse when every channel has delivered all of its elements.
REQ-013 err  out  1  sticky error flag.
REQ-014 arid_m/araddr_m/arlen_m/arsize_m/arvalid_m  out  16/64/8/3/1  AXI read-address channel.
REQ-015 arready_m  in  1  AXI read-address ready.
REQ-016 rid_m/rdata_m/rresp_m/rlast_m/rvalid_m  in  16/DATA_W/2/1/1  AXI read-data channel.
REQ-017 rready_m  out  1  AXI read-data ready.
REQ-018 out_valid/out_ready  out/in  NUM_CH each  per-channel element handshake.
REQ-019 out_data  out  NUM_CH*ELEM_W  per-channel element; channel c occupies slice [c*ELEM_W +: ELEM_W].

Function
REQ-020 start SHALL be accepted only when busy=0; a start pulse while busy SHALL be ignored.
REQ-021 Per channel: lines L = ceil(count*ELEM_W/DATA_W); next address = base; remaining lines = L.
REQ-022 Channel c SHALL be eligible to request when remaining>0 AND fifo_occ + outstanding + B <= D, where B = min(remaining, MAX_BURST, beats left before the next 4 KB boundary).
REQ-023 arlen_m = B-1; arsize_m = 3'b110; arid_m = c; araddr_m = the channel's current address.
REQ-024 Arbitration SHALL be round-robin among eligible channels; the pointer moves to the next channel after the granted channel only on an AR handshake.
REQ-025 While arvalid_m=1 and arready_m=0, all AR outputs SHALL be held stable.
REQ-026 On an AR handshake: outstanding += B; address += 64*B; remaining -= B.
REQ-027 rready_m = 1 whenever out of reset; the credit rule in REQ-022 guarantees FIFO space for every beat.
REQ-028 A beat with rid_m < NUM_CH SHALL be written to that channel's FIFO and decrement its outstanding count by 1.
REQ-029 A beat with rid_m >= NUM_CH SHALL be dropped and SHALL set err.
REQ-030 Any beat with rresp_m != 0 SHALL set err; its data SHALL still be delivered.
REQ-031 Unpacker: each channel emits the head line's elements lowest-index first (bits [ELEM_W-1:0] first).
REQ-032 The head line SHALL be popped after its last element handshakes.
REQ-033 The final line of a channel SHALL emit only count - (L-1)*E elements.
REQ-034 out_valid SHALL stay asserted and out_data stable until out_ready is sampled high.
REQ-035 A channel is complete when it has handshaked count elements; a channel with count=0 is complete immediately.
REQ-036 done SHALL pulse in the cycle after the last channel completes; busy SHALL clear in the same cycle.
REQ-037 With all counts 0, done SHALL pulse one cycle after start.
REQ-038 err SHALL be cleared by an accepted start or by reset.
REQ-039 Simultaneous FIFO write and pop in one cycle SHALL leave the occupancy count unchanged.

Reset
REQ-040 rst_n=0 SHALL asynchronously clear: arvalid_m, out_valid, busy, done and err; all counters; FIFO pointers; the round-robin pointer (to channel 0).
REQ-041 Reset asserted mid-operation SHALL discard all outstanding state; beats arriving after reset release with no active transfer SHALL be dropped without setting err.
REQ-042 All other outputs SHALL reset to 0, except rready_m, which is 1 after reset release.

Verification
REQ-043 Basic two-channel run: ch0 base 0x1000 count 16, ch1 base 0x2000 count 3, arready_m=1, out_ready=1.
  Required: AR (id0, 0x1000, arlen 1) and AR (id1, 0x2000, arlen 0); 16 and 3 elements delivered in order; exactly one done pulse.
REQ-044 4 KB boundary: base 0xFC0, count 32.
  Required: AR 0xFC0 arlen 0, then AR 0x1000 arlen 2.
REQ-045 Backpressure: out_ready=0, count 256.
  Required: exactly 16 lines requested, then arvalid_m stays low; after out_ready=1, all 256 elements arrive with none lost.
REQ-046 Error response: rresp_m=2 on one beat.
  Required: err=1 and held until the next start; data still emitted.
REQ-047 Reset mid-run: rst_n pulsed low with 3 beats outstanding.
  Required: all outputs at reset values; a subsequent start runs to done with correct data.
REQ-048 Empty run and ignored start: start with all counts 0.
  Required: done pulses one cycle later; a start issued while busy is ignored.

Source files
------------

// File: rtl/pr_stream_reader.sv
// Multi-channel AXI read streamer: credit-checked burst requests per channel,
// per-channel line FIFOs and element unpackers feeding valid/ready outputs.
module pr_stream_reader #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 512,
  parameter int ELEM_W    = 64,
  parameter int LOG_DEPTH = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH*64-1:0]     cfg_base,
  input  logic [NUM_CH*64-1:0]     cfg_count,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [15:0]              arid_m,
  output logic [63:0]              araddr_m,
  output logic [7:0]               arlen_m,
  output logic [2:0]               arsize_m,
  output logic                     arvalid_m,
  input  logic                     arready_m,
  input  logic [15:0]              rid_m,
  input  logic [DATA_W-1:0]        rdata_m,
  input  logic [1:0]               rresp_m,
  input  logic                     rlast_m,
  input  logic                     rvalid_m,
  output logic                     rready_m,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*ELEM_W-1:0] out_data
);
  localparam int E     = DATA_W / ELEM_W;
  localparam int LOG_E = $clog2(E);
  localparam int D     = 1 << LOG_DEPTH;
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OW    = LOG_DEPTH + 1;

  typedef enum logic {AR_IDLE, AR_WAIT} ar_state_t;
  ar_state_t ar_state;

  logic [63:0]          addr_q  [NUM_CH];
  logic [63:0]          rem_q   [NUM_CH];
  logic [63:0]          count_q [NUM_CH];
  logic [63:0]          sent_q  [NUM_CH];
  logic [OW-1:0]        occ_q   [NUM_CH];
  logic [OW-1:0]        outs_q  [NUM_CH];
  logic [LOG_DEPTH-1:0] wr_ptr  [NUM_CH];
  logic [LOG_DEPTH-1:0] rd_ptr  [NUM_CH];
  logic [LOG_E-1:0]     idx_q   [NUM_CH];
  logic [DATA_W-1:0]    mem     [NUM_CH][D];
  logic [8:0]           burst   [NUM_CH];
  logic [CHW-1:0]       rr_q, gnt;
  logic                 gnt_any, r_hs, r_bad;
  logic [NUM_CH-1:0]    elig, wr_en, out_hs, pop, fin;
  logic [8:0]           ar_beats;
  logic                 unused;

  assign unused   = ^{rlast_m, cfg_base};
  assign ar_beats = {1'b0, arlen_m} + 9'd1;

  function automatic logic [63:0] lines_of(input logic [63:0] n);
    return (n >> LOG_E) + 64'(|n[LOG_E-1:0]);
  endfunction

  // Burst size is capped by remaining lines, MAX_BURST and the next 4 KB page.
  // NOTE: combinational blocks use blocking '=' and give every target a default
  // first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    int b;
    b    = 0;
    elig = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      b = MAX_BURST;
      if (64 - int'(addr_q[c][11:6]) < b) b = 64 - int'(addr_q[c][11:6]);
      if (rem_q[c] < 64'(b)) b = int'(rem_q[c][8:0]);
      burst[c] = 9'(b);
      elig[c]  = busy && (rem_q[c] != 64'd0) &&
                 (int'(occ_q[c]) + int'(outs_q[c]) + b <= D);
    end
  end

  always_comb begin
    int ci;
    ci      = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      ci = (int'(rr_q) + k) % NUM_CH;
      if (!gnt_any && elig[ci]) begin
        gnt_any = 1'b1;
        gnt     = CHW'(ci);
      end
    end
  end

  always_comb begin
    logic [DATA_W-1:0] head;
    head      = '0;
    out_data  = '0;
    out_valid = '0;
    out_hs    = '0;
    pop       = '0;
    fin       = '0;
    wr_en     = '0;
    r_hs      = rvalid_m && rready_m;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_en[c]     = busy && r_hs && (rid_m == 16'(c)) && (outs_q[c] != '0);
      out_valid[c] = busy && (occ_q[c] != '0) && (sent_q[c] != count_q[c]);
      head         = mem[c][rd_ptr[c]];
      out_data[c*ELEM_W +: ELEM_W] = head[idx_q[c]*ELEM_W +: ELEM_W];
      out_hs[c]    = out_valid[c] && out_ready[c];
      pop[c]       = out_hs[c] && ((idx_q[c] == LOG_E'(E-1)) ||
                                   (sent_q[c] + 64'd1 == count_q[c]));
      fin[c]       = (sent_q[c] == count_q[c]) ||
                     (out_hs[c] && (sent_q[c] + 64'd1 == count_q[c]));
    end
    // Unknown id, unrequested beat or error response all flag err.
    r_bad = busy && r_hs && ((rresp_m != 2'b00) || (wr_en == '0));
  end

  // NOTE: line storage has no reset; occupancy and pointers alone say which
  // entries hold valid data.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (wr_en[c]) mem[c][wr_ptr[c]] <= rdata_m;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_state  <= AR_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rr_q      <= '0;
      arid_m    <= '0;
      araddr_m  <= '0;
      arlen_m   <= '0;
      arsize_m  <= '0;
      arvalid_m <= 1'b0;
      rready_m  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        addr_q[c]  <= '0;
        rem_q[c]   <= '0;
        count_q[c] <= '0;
        sent_q[c]  <= '0;
        occ_q[c]   <= '0;
        outs_q[c]  <= '0;
        wr_ptr[c]  <= '0;
        rd_ptr[c]  <= '0;
        idx_q[c]   <= '0;
      end
    end else begin
      done     <= 1'b0;
      rready_m <= 1'b1;
      if (start && !busy) begin
        err  <= 1'b0;
        busy <= (cfg_count != '0);
        done <= (cfg_count == '0);
        for (int c = 0; c < NUM_CH; c++) begin
          addr_q[c]  <= {cfg_base[c*64+6 +: 58], 6'b0};
          count_q[c] <= cfg_count[c*64 +: 64];
          rem_q[c]   <= lines_of(cfg_count[c*64 +: 64]);
          sent_q[c]  <= '0;
          occ_q[c]   <= '0;
          outs_q[c]  <= '0;
          wr_ptr[c]  <= '0;
          rd_ptr[c]  <= '0;
          idx_q[c]   <= '0;
        end
      end else if (busy) begin
        if (r_bad) err <= 1'b1;
        case (ar_state)
          AR_IDLE: if (gnt_any) begin
            ar_state  <= AR_WAIT;
            arvalid_m <= 1'b1;
            arid_m    <= 16'(gnt);
            araddr_m  <= addr_q[gnt];
            arlen_m   <= 8'(burst[gnt] - 9'd1);
            arsize_m  <= 3'b110;
          end
          AR_WAIT: if (arready_m) begin
            ar_state  <= AR_IDLE;
            arvalid_m <= 1'b0;
            rr_q      <= (arid_m[CHW-1:0] == CHW'(NUM_CH-1)) ? '0 : arid_m[CHW-1:0] + 1'b1;
          end
          default: ar_state <= AR_IDLE;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
          if (ar_state == AR_WAIT && arready_m && arid_m[CHW-1:0] == CHW'(c)) begin
            addr_q[c] <= addr_q[c] + 64'({ar_beats, 6'b0});
            rem_q[c]  <= rem_q[c] - 64'(ar_beats);
            outs_q[c] <= outs_q[c] + OW'(ar_beats) - OW'(wr_en[c]);
          end else begin
            outs_q[c] <= outs_q[c] - OW'(wr_en[c]);
          end
          occ_q[c] <= occ_q[c] + OW'(wr_en[c]) - OW'(pop[c]);
          if (wr_en[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
          if (out_hs[c]) begin
            sent_q[c] <= sent_q[c] + 64'd1;
            if (pop[c]) begin
              idx_q[c]  <= '0;
              rd_ptr[c] <= rd_ptr[c] + 1'b1;
            end else begin
              idx_q[c] <= idx_q[c] + 1'b1;
            end
          end
        end
        if (&fin) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pr_stream_reader.sv
// Directed bench for pr_stream_reader: an AXI slave model returns lines whose
// elements equal their byte address / 8, so every output element is predictable.
module tb_pr_stream_reader;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 512;
  localparam int ELEM_W = 64;
  localparam int E      = DATA_W / ELEM_W;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     start = 1'b0;
  logic [NUM_CH*64-1:0]     cfg_base = '0;
  logic [NUM_CH*64-1:0]     cfg_count = '0;
  logic                     busy, done, err;
  logic [15:0]              arid_m;
  logic [63:0]              araddr_m;
  logic [7:0]               arlen_m;
  logic [2:0]               arsize_m;
  logic                     arvalid_m;
  logic                     arready_m = 1'b1;
  logic [15:0]              rid_m = '0;
  logic [DATA_W-1:0]        rdata_m = '0;
  logic [1:0]               rresp_m = '0;
  logic                     rlast_m = 1'b0;
  logic                     rvalid_m = 1'b0;
  logic                     rready_m;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready = '1;
  logic [NUM_CH*ELEM_W-1:0] out_data;

  always #5 clk = ~clk;

  pr_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base), .cfg_count(cfg_count),
    .busy(busy), .done(done), .err(err),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  typedef struct packed {
    logic [15:0] id;
    logic [63:0] addr;
    logic        last;
  } beat_t;

  beat_t       bq[$];
  int          ar_n = 0;
  logic [15:0] ar_id_log   [64];
  logic [63:0] ar_addr_log [64];
  logic [7:0]  ar_len_log  [64];
  int          beat_n = 0;
  int          err_beat = -1;
  logic        r_stall = 1'b0;
  logic        s_ar_hs, s_r_hs;

  function automatic logic [DATA_W-1:0] line_data(input logic [63:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int k = 0; k < E; k++) d[k*ELEM_W +: ELEM_W] = (a >> 3) + 64'(k);
    return d;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      s_ar_hs = arvalid_m && arready_m;
      s_r_hs  = rvalid_m && rready_m;
      if (s_ar_hs) begin
        if (ar_n < 64) begin
          ar_id_log[ar_n]   = arid_m;
          ar_addr_log[ar_n] = araddr_m;
          ar_len_log[ar_n]  = arlen_m;
        end
        ar_n++;
        for (int k = 0; k <= int'(arlen_m); k++)
          bq.push_back('{id: arid_m, addr: araddr_m + 64'(k * 64), last: (k == int'(arlen_m))});
      end
      @(posedge clk);
      #1;
      if (s_r_hs && bq.size() > 0) begin
        void'(bq.pop_front());
        beat_n++;
      end
      if (!rst_n) bq.delete();
      if (bq.size() > 0 && !r_stall && rst_n) begin
        rvalid_m = 1'b1;
        rid_m    = bq[0].id;
        rdata_m  = line_data(bq[0].addr);
        rlast_m  = bq[0].last;
        rresp_m  = (beat_n == err_beat) ? 2'd2 : 2'd0;
      end else begin
        rvalid_m = 1'b0;
        rresp_m  = 2'd0;
      end
    end
  end

  // ---------------- output monitor ----------------
  int          recv [NUM_CH];
  logic [63:0] exp_base [NUM_CH];
  int          done_n = 0;

  always @(negedge clk) begin
    if (done) done_n++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (out_valid[c] && out_ready[c]) begin
        check($sformatf("ch%0d_elem%0d", c, recv[c]), out_data[c*ELEM_W +: ELEM_W],
              (exp_base[c] >> 3) + 64'(recv[c]));
        recv[c]++;
      end
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [63:0] b0, input logic [63:0] c0,
                          input logic [63:0] b1, input logic [63:0] c1);
    cfg_base    = {b1, b0};
    cfg_count   = {c1, c0};
    exp_base[0] = b0;
    exp_base[1] = b1;
    recv[0]     = 0;
    recv[1]     = 0;
    done_n      = 0;
    ar_n        = 0;
    beat_n      = 0;
    start       = 1'b1;
    cycle(1);
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      cycle(1);
      n++;
    end
    check({name, "_done_seen"}, 64'(done), 64'd1);
  endtask

  // ---------------- directed run table ----------------
  typedef struct {
    string       name;
    logic [63:0] b0, c0, b1, c1;
    int          nar;
    logic [15:0] id0;
    logic [63:0] a0;
    logic [7:0]  l0;
    logic [15:0] id1;
    logic [63:0] a1;
    logic [7:0]  l1;
    logic        restart;
  } vec_t;

  vec_t vt[3];
  int   n, sum;

  initial begin
    // Round-robin pointer carries over between runs: after run 0 it points at
    // ch0, after run 1 (ch0 only) it points at ch1, so run 2 grants ch1 first.
    vt[0] = '{"basic", 64'h1000, 64'd16, 64'h2000, 64'd3, 2,
              16'd0, 64'h1000, 8'd1, 16'd1, 64'h2000, 8'd0, 1'b1};
    vt[1] = '{"page4k", 64'hFC0, 64'd32, 64'h0, 64'd0, 2,
              16'd0, 64'hFC0, 8'd0, 16'd0, 64'h1000, 8'd2, 1'b0};
    vt[2] = '{"rr_mix", 64'h0, 64'd5, 64'h3000, 64'd40, 3,
              16'd1, 64'h3000, 8'd3, 16'd0, 64'h0, 8'd0, 1'b0};

    // Reset values.
    #2 rst_n = 1'b0;
    cycle(2);
    check("rst_arvalid", 64'(arvalid_m), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_araddr", araddr_m, 64'd0);
    check("rst_arlen", 64'(arlen_m), 64'd0);
    rst_n = 1'b1;
    cycle(1);
    check("rready_after_rst", 64'(rready_m), 64'd1);

    // Empty run: done one cycle after start, busy never raised.
    do_start(64'h0, 64'd0, 64'h0, 64'd0);
    check("empty_done", 64'(done), 64'd1);
    check("empty_busy", 64'(busy), 64'd0);
    cycle(1);
    check("empty_done_pulse", 64'(done), 64'd0);

    for (int i = 0; i < 3; i++) begin
      do_start(vt[i].b0, vt[i].c0, vt[i].b1, vt[i].c1);
      check({vt[i].name, "_busy"}, 64'(busy), 64'd1);
      if (vt[i].restart) begin
        cycle(3);
        cfg_count = {64'd1, 64'd1};
        start = 1'b1;
        cycle(1);
        start = 1'b0;
      end
      wait_done(vt[i].name, 2000);
      cycle(3);
      check({vt[i].name, "_recv0"}, 64'(recv[0]), vt[i].c0);
      check({vt[i].name, "_recv1"}, 64'(recv[1]), vt[i].c1);
      check({vt[i].name, "_done_pulses"}, 64'(done_n), 64'd1);
      check({vt[i].name, "_ar_count"}, 64'(ar_n), 64'(vt[i].nar));
      check({vt[i].name, "_ar0_id"}, 64'(ar_id_log[0]), 64'(vt[i].id0));
      check({vt[i].name, "_ar0_addr"}, ar_addr_log[0], vt[i].a0);
      check({vt[i].name, "_ar0_len"}, 64'(ar_len_log[0]), 64'(vt[i].l0));
      check({vt[i].name, "_ar1_id"}, 64'(ar_id_log[1]), 64'(vt[i].id1));
      check({vt[i].name, "_ar1_addr"}, ar_addr_log[1], vt[i].a1);
      check({vt[i].name, "_ar1_len"}, 64'(ar_len_log[1]), 64'(vt[i].l1));
      check({vt[i].name, "_err"}, 64'(err), 64'd0);
      check({vt[i].name, "_busy_end"}, 64'(busy), 64'd0);
    end
    check("arsize", 64'(arsize_m), 64'd6);

    // Error response on the second beat: data still delivered, err sticky.
    err_beat = 1;
    do_start(64'h4000, 64'd16, 64'h0, 64'd0);
    wait_done("errresp", 2000);
    err_beat = -1;
    cycle(5);
    check("errresp_err", 64'(err), 64'd1);
    check("errresp_recv", 64'(recv[0]), 64'd16);
    do_start(64'h0, 64'd0, 64'h0, 64'd0);
    check("err_cleared_by_start", 64'(err), 64'd0);
    cycle(2);

    // Backpressure: the FIFO credit stops requests after D lines.
    out_ready = '0;
    do_start(64'h8000, 64'd256, 64'h0, 64'd0);
    cycle(120);
    sum = 0;
    for (int k = 0; k < ar_n && k < 64; k++) sum += int'(ar_len_log[k]) + 1;
    check("bp_lines_requested", 64'(sum), 64'd16);
    check("bp_arvalid_low", 64'(arvalid_m), 64'd0);
    check("bp_none_out", 64'(recv[0]), 64'd0);
    out_ready = '1;
    wait_done("bp", 5000);
    cycle(2);
    check("bp_recv", 64'(recv[0]), 64'd256);

    // AR hold under arready=0, then reset with three beats outstanding.
    r_stall   = 1'b1;
    arready_m = 1'b0;
    do_start(64'h5000, 64'd24, 64'h0, 64'd0);
    n = 0;
    while (!arvalid_m && n < 20) begin
      cycle(1);
      n++;
    end
    check("hold_arvalid", 64'(arvalid_m), 64'd1);
    cycle(3);
    check("hold_arvalid_still", 64'(arvalid_m), 64'd1);
    check("hold_araddr", araddr_m, 64'h5000);
    check("hold_arlen", 64'(arlen_m), 64'd2);
    check("hold_arid", 64'(arid_m), 64'd0);
    arready_m = 1'b1;
    cycle(3);
    check("midrst_ar_done", 64'(ar_n), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_arvalid", 64'(arvalid_m), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    cycle(2);
    rst_n   = 1'b1;
    r_stall = 1'b0;
    cycle(2);
    do_start(64'h6000, 64'd20, 64'hA000, 64'd9);
    wait_done("post_rst", 2000);
    cycle(3);
    check("post_rst_recv0", 64'(recv[0]), 64'd20);
    check("post_rst_recv1", 64'(recv[1]), 64'd9);
    check("post_rst_done_pulses", 64'(done_n), 64'd1);
    check("post_rst_err", 64'(err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
